run_detect_fsm: RTL and testbench
=================================

// Module: run_detect_fsm
// PURPOSE
//  Parametrised one-hot Moore FSM for run-length detection on a serial bit
//  stream w. Flags when the last RUN_LEN accepted samples are all 0 or all 1.
//  Successor to the fixed two-sample detector: depth is set by RUN_LEN, and
//  the block adds a sample-enable, a sync clear, per-polarity detect masks
//  and a run-count output.
//  Sits between the serial-input sampler and downstream control logic.
// PARAMETERS
//  RUN_LEN  2                     consecutive equal samples needed to flag; legal range >= 1
//  SW       2*RUN_LEN+1           state vector width (derived; do not override)
//  CW       $clog2(RUN_LEN+1)     run_cnt width (derived)
// PORTS
//  clk       in   1    rising-edge clock
//  reset     in   1    asynchronous, active-high reset
//  w         in   1    serial sample
//  w_en      in   1    sample qualifier; w is consumed only when w_en=1
//  clear     in   1    synchronous return to IDLE; priority over w_en
//  det_zero  in   1    enable the all-zeros detection
//  det_one   in   1    enable the all-ones detection
//  z         out  1    z_zero | z_one
//  z_zero    out  1    zero-run detected
//  z_one     out  1    one-run detected
//  run_cnt   out  CW   length of current run, saturating at RUN_LEN
//  state     out  SW   one-hot state vector
//  err       out  1    illegal (non-one-hot) state flag
// BEHAVIOUR
//  - State bit layout: bit0 = IDLE; bits 1..RUN_LEN = Z1..Z_RUN_LEN
//    (k zeros seen); bits RUN_LEN+1..2*RUN_LEN = O1..O_RUN_LEN (k ones seen).
//  - reset=1, asynchronous: state = IDLE only (bit0=1). All outputs read 0
//    (z, z_zero, z_one, run_cnt, err). Reset asserted mid-run aborts the run.
//  - Per clk edge, in priority order:
//    - clear=1: next state = IDLE.
//    - w_en=0: hold state.
//    - w_en=1, w=0: IDLE or any Ok -> Z1; Zk -> Z(min(k+1, RUN_LEN)).
//    - w_en=1, w=1: IDLE or any Zk -> O1; Ok -> O(min(k+1, RUN_LEN)).
//  - Saturation: Z_RUN_LEN and O_RUN_LEN self-loop while the polarity holds.
//    There is no wrap-around.
//  - Outputs are Moore, decoded from the state flops. The det_* gating is
//    combinational.
//    - z_zero = state[RUN_LEN] & det_zero.
//    - z_one  = state[2*RUN_LEN] & det_one.
//  - Latency: z rises in the cycle after the edge that accepts the
//    RUN_LEN-th equal sample. It falls in the cycle after the first opposite
//    sample, or after clear.
//  - run_cnt = k in Zk or Ok, and 0 in IDLE.
//  - RUN_LEN=1: a single accepted sample sets the matching output.
//  - Clearing both det_* inputs masks the flags only; the state still advances.
// CONFIGURATION
//  ONEHOT_CHECK_EN defined:
//    - err = 1 (combinational) whenever popcount(state) != 1.
//    - The next clk edge forces IDLE, overriding clear, w_en and w.
//  ONEHOT_CHECK_EN undefined:
//    - err is tied to 0.
//    - No recovery logic is built; next-state equations are used as written.
// STRUCTURE
//  - Package run_detect_pkg holds:
//    - localparam IDX_IDLE = 0;
//    - functions zidx(k) = k and oidx(k) = RUN_LEN+k;
//    - function onehot_ok(vec).
//  - Sub-module dff_preset: a single-bit flop with parameter RST_VAL and
//    async active-high reset. Instantiate one per state bit in a generate loop:
//    RST_VAL=1 for bit0, 0 for all other bits.
// TESTING (RUN_LEN=2 unless noted)
//  1. Reset pulse -> state=5'b00001, z=0, run_cnt=0, err=0; reset mid-run
//     -> state=5'b00001 with no clock edge.
//  2. w_en=1, w=0,0,0 -> state Z1,Z2,Z2; run_cnt 1,2,2; z_zero/z =1 from
//     after the 2nd edge.
//  3. w=0,0,1,1 -> z_zero falls after the 3rd edge (state O1), z_one rises
//     after the 4th edge; z stays low for one cycle.
//  4. w=0, then w_en=0 for 3 cycles, then w=0 -> state held at Z1, then Z2;
//     clear=1 with w_en=1,w=0 -> IDLE.
//  5. det_zero=0, w=0,0 -> run_cnt=2, z_zero=0, z=0; RUN_LEN=4 with w=1 x5
//     -> run_cnt saturates at 4, z_one=1.
//  6. ONEHOT_CHECK_EN: force state=5'b00110 -> err=1, next edge -> 5'b00001,
//     err=0; without the macro, err stays 0.

Source files
------------

// File: rtl/run_detect_pkg.sv
// Shared indices and helpers for the run-length detector FSM.
package run_detect_pkg;

    localparam int IDX_IDLE = 0;
    localparam int MAX_SW   = 64;

    function automatic int zidx(input int k);
        return k;
    endfunction

    function automatic int oidx(input int run_len, input int k);
        return run_len + k;
    endfunction

    function automatic logic onehot_ok(input logic [MAX_SW-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_SW; i++) begin
            cnt += int'(vec[i]);
        end
        return (cnt == 32'sd1);
    endfunction

endpackage

// File: rtl/run_detect_fsm_dff_preset.sv
// Single-bit state flop with selectable asynchronous reset value.
module dff_preset #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    // state bit storage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/run_detect_fsm.sv
// One-hot Moore run-length detector; define ONEHOT_CHECK_EN to flag and
// recover from non-one-hot states.
module run_detect_fsm
    import run_detect_pkg::*;
#(
    parameter int RUN_LEN = 2,
    parameter int SW      = 2*RUN_LEN+1,
    parameter int CW      = $clog2(RUN_LEN+1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          w,
    input  logic          w_en,
    input  logic          clear,
    input  logic          det_zero,
    input  logic          det_one,
    output logic          z,
    output logic          z_zero,
    output logic          z_one,
    output logic [CW-1:0] run_cnt,
    output logic [SW-1:0] state,
    output logic          err
);

    localparam int ZLO = zidx(1);
    localparam int ZHI = zidx(RUN_LEN);
    localparam int OLO = oidx(RUN_LEN, 1);
    localparam int OHI = oidx(RUN_LEN, RUN_LEN);
    localparam logic [SW-1:0] IDLE_VEC = {{(SW-1){1'b0}}, 1'b1};

    logic [SW-1:0]      nxt;
    logic [RUN_LEN-1:0] zeros;
    logic [RUN_LEN-1:0] ones;
    logic [RUN_LEN-1:0] zero_step;
    logic [RUN_LEN-1:0] one_step;
    logic               bad_state;

    assign zeros = state[ZHI:ZLO];
    assign ones  = state[OHI:OLO];

`ifdef ONEHOT_CHECK_EN
    assign bad_state = ~onehot_ok(MAX_SW'(state));
`else
    assign bad_state = 1'b0;
`endif

    // state register: bit0 presets to IDLE, all others clear
    for (genvar b = 0; b < SW; b++) begin : g_state
        dff_preset #(
            .RST_VAL((b == IDX_IDLE) ? 1'b1 : 1'b0)
        ) u_ff (
            .clk   (clk),
            .reset (reset),
            .d     (nxt[b]),
            .q     (state[b])
        );
    end

    // next-state: advance within a polarity, restart on the opposite one
    always_comb begin
        zero_step = (zeros << 1) | RUN_LEN'(state[IDX_IDLE] | (|ones));
        one_step  = (ones  << 1) | RUN_LEN'(state[IDX_IDLE] | (|zeros));
        // the top bit of each chain self-loops (saturation)
        zero_step[RUN_LEN-1] = zero_step[RUN_LEN-1] | zeros[RUN_LEN-1];
        one_step[RUN_LEN-1]  = one_step[RUN_LEN-1]  | ones[RUN_LEN-1];
        nxt = state;
        if (bad_state || clear) begin
            nxt = IDLE_VEC;
        end else if (w_en) begin
            if (w) begin
                nxt = {one_step, {RUN_LEN{1'b0}}, 1'b0};
            end else begin
                nxt = {{RUN_LEN{1'b0}}, zero_step, 1'b0};
            end
        end else begin
            nxt = state;
        end
    end

    // Moore outputs decoded from the state flops
    always_comb begin
        z_zero  = state[ZHI] & det_zero;
        z_one   = state[OHI] & det_one;
        z       = z_zero | z_one;
        err     = bad_state;
        run_cnt = '0;
        for (int k = 1; k <= RUN_LEN; k++) begin
            run_cnt = (zeros[k-1] | ones[k-1]) ? CW'(k) : run_cnt;
        end
    end

endmodule

// File: tb/tb_run_detect_fsm.sv
// Randomized bench for run_detect_fsm at RUN_LEN=2 and RUN_LEN=4 against a
// run-length reference model.
module tb_run_detect_fsm;

    logic clk = 1'b0;
    logic reset;
    logic w, w_en, clear, det_zero, det_one;

    logic       z2, zz2, zo2, err2;
    logic [1:0] cnt2;
    logic [4:0] st2;
    logic       z4, zz4, zo4, err4;
    logic [2:0] cnt4;
    logic [8:0] st4;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int len  [2] = '{2, 4};
    int run  [2];
    int last [2];

    run_detect_fsm #(.RUN_LEN(2)) u_dut2 (
        .clk(clk), .reset(reset), .w(w), .w_en(w_en), .clear(clear),
        .det_zero(det_zero), .det_one(det_one), .z(z2), .z_zero(zz2),
        .z_one(zo2), .run_cnt(cnt2), .state(st2), .err(err2)
    );

    run_detect_fsm #(.RUN_LEN(4)) u_dut4 (
        .clk(clk), .reset(reset), .w(w), .w_en(w_en), .clear(clear),
        .det_zero(det_zero), .det_one(det_one), .z(z4), .z_zero(zz4),
        .z_one(zo4), .run_cnt(cnt4), .state(st4), .err(err4)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int exp_state(input int i);
        if (run[i] == 0) return 1;
        return 1 << ((last[i] != 0) ? len[i] + run[i] : run[i]);
    endfunction

    function automatic int exp_zz(input int i);
        return (run[i] == len[i] && last[i] == 0 && det_zero) ? 1 : 0;
    endfunction

    function automatic int exp_zo(input int i);
        return (run[i] == len[i] && last[i] == 1 && det_one) ? 1 : 0;
    endfunction

    task automatic check_all();
        check_val("st2",  int'(st2),  exp_state(0));
        check_val("cnt2", int'(cnt2), run[0]);
        check_val("zz2",  int'(zz2),  exp_zz(0));
        check_val("zo2",  int'(zo2),  exp_zo(0));
        check_val("z2",   int'(z2),   exp_zz(0) | exp_zo(0));
        check_val("err2", int'(err2), 0);
        check_val("st4",  int'(st4),  exp_state(1));
        check_val("cnt4", int'(cnt4), run[1]);
        check_val("zz4",  int'(zz4),  exp_zz(1));
        check_val("zo4",  int'(zo4),  exp_zo(1));
        check_val("z4",   int'(z4),   exp_zz(1) | exp_zo(1));
        check_val("err4", int'(err4), 0);
    endtask

    task automatic step(input logic c, input logic en, input logic wv,
                        input logic dz, input logic d1);
        @(negedge clk);
        clear = c; w_en = en; w = wv; det_zero = dz; det_one = d1;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (c) begin
                run[i] = 0;
            end else if (en) begin
                if (run[i] == 0 || last[i] != int'(wv)) begin
                    run[i]  = 1;
                    last[i] = int'(wv);
                end else if (run[i] < len[i]) begin
                    run[i]++;
                end
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic wr;
        reset = 1'b1; w = 1'b0; w_en = 1'b0; clear = 1'b0;
        det_zero = 1'b1; det_one = 1'b1;
        run = '{0, 0}; last = '{0, 0};
        #2;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // zeros run up to saturation, then polarity flip
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        // hold with w_en low, then clear overriding an accepted sample
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        // masked detection still advances state; long ones run saturates at 4
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);

        // asynchronous reset mid-run, checked before any clock edge
        @(negedge clk);
        w_en = 1'b0; clear = 1'b0;
        #2 reset = 1'b1;
        #1;
        run = '{0, 0};
        check_all();
        #1 reset = 1'b0;

        wr = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) wr = ~wr;
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), wr,
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
